// File: rtl/dcache_sram_nway.sv
// N-way set-associative data-cache storage: valid/dirty/tag/data arrays with true-LRU ages,
// combinational lookup, clocked updates and a flush engine that streams dirty lines to write-back.
module dcache_sram_nway #(
  parameter int WAYS   = 4,
  parameter int SETS   = 16,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256,
  parameter int IDX_W  = $clog2(SETS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  output logic [TAG_W+1:0]  tag_o,
  output logic [LINE_W-1:0] data_o,
  output logic              hit_o,
  input  logic              flush_i,
  input  logic              flush_inv_i,
  output logic              flush_busy_o,
  output logic              flush_done_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [IDX_W-1:0]  wb_idx_o,
  output logic [TAG_W-1:0]  wb_tag_o,
  output logic [LINE_W-1:0] wb_data_o
);
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_EMIT, ST_DONE} state_e;
  typedef logic [WAYS-1:0][WAY_W-1:0] set_age_t;

  state_e state_q, state_d;

  logic [SETS-1:0][WAYS-1:0][LINE_W-1:0] data_q;
  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]  tag_q;
  logic [SETS-1:0][WAYS-1:0]             valid_q;
  logic [SETS-1:0][WAYS-1:0]             dirty_q;
  set_age_t [SETS-1:0]                   age_q;

  logic [IDX_W-1:0] set_ptr_q;
  logic [WAY_W-1:0] way_ptr_q;
  logic             inv_q;

  logic             lookup_en;
  logic [WAYS-1:0]  hit_vec;
  logic             any_hit;
  logic [WAY_W-1:0] hit_way, victim_way, sel_way;

  logic last_line, line_dirty, scan_skip, wb_fire, advance;

  // Ages start as the identity permutation: way w has age w.
  function automatic set_age_t reset_ages();
    set_age_t a;
    for (int w = 0; w < WAYS; w++) a[w] = WAY_W'(w);
    return a;
  endfunction

  assign lookup_en = enable_i && (state_q == ST_IDLE);

  // NOTE: every variable gets a default at the top of a combinational block so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    hit_vec    = '0;
    hit_way    = '0;
    victim_way = '0;
    for (int w = 0; w < WAYS; w++)
      hit_vec[w] = valid_q[addr_i][w] && (tag_q[addr_i][w] == tag_i);
    for (int w = WAYS - 1; w >= 0; w--)
      if (hit_vec[w]) hit_way = WAY_W'(w);
    for (int w = 0; w < WAYS; w++)
      if (age_q[addr_i][w] == WAY_W'(WAYS - 1)) victim_way = WAY_W'(w);
    // The descending scan lets the lowest-index invalid way override the LRU choice.
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[addr_i][w]) victim_way = WAY_W'(w);
  end

  assign any_hit = |hit_vec;
  assign sel_way = any_hit ? hit_way : victim_way;

  always_comb begin
    hit_o  = 1'b0;
    tag_o  = '0;
    data_o = '0;
    if (lookup_en) begin
      hit_o  = any_hit;
      tag_o  = {valid_q[addr_i][sel_way], dirty_q[addr_i][sel_way], tag_q[addr_i][sel_way]};
      data_o = data_q[addr_i][sel_way];
    end
  end

  assign last_line  = (set_ptr_q == IDX_W'(SETS - 1)) && (way_ptr_q == WAY_W'(WAYS - 1));
  assign line_dirty = valid_q[set_ptr_q][way_ptr_q] && dirty_q[set_ptr_q][way_ptr_q];
  assign scan_skip  = (state_q == ST_SCAN) && !line_dirty;
  assign wb_fire    = (state_q == ST_EMIT) && wb_ready_i;
  assign advance    = scan_skip || wb_fire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (flush_i) state_d = ST_SCAN;
      ST_SCAN: begin
        if (line_dirty)     state_d = ST_EMIT;
        else if (last_line) state_d = ST_DONE;
      end
      ST_EMIT: if (wb_ready_i) state_d = last_line ? ST_DONE : ST_SCAN;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Nothing is written during a flush, so the presented line stays stable until the handshake.
  always_comb begin
    flush_busy_o = (state_q != ST_IDLE);
    flush_done_o = (state_q == ST_DONE);
    wb_valid_o   = (state_q == ST_EMIT);
    wb_idx_o     = '0;
    wb_tag_o     = '0;
    wb_data_o    = '0;
    if (state_q == ST_EMIT) begin
      wb_idx_o  = set_ptr_q;
      wb_tag_o  = tag_q[set_ptr_q][way_ptr_q];
      wb_data_o = data_q[set_ptr_q][way_ptr_q];
    end
  end

  // NOTE: the whole array is cleared by reset because the contents are observable on tag_o/data_o
  // and on the write-back port straight after reset; this costs reset fan-out on every bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q    <= '0;
      tag_q     <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
      age_q     <= {SETS{reset_ages()}};
      set_ptr_q <= '0;
      way_ptr_q <= '0;
      inv_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking updates mean every comparison below sees the ages from before this
      // access, so the touched way's own age is compared against its old value.
      if (lookup_en && (write_i || any_hit)) begin
        for (int w = 0; w < WAYS; w++)
          if (age_q[addr_i][w] < age_q[addr_i][sel_way])
            age_q[addr_i][w] <= age_q[addr_i][w] + WAY_W'(1);
        age_q[addr_i][sel_way] <= '0;
      end

      if (lookup_en && write_i) begin
        data_q[addr_i][sel_way] <= data_i;
        if (any_hit) begin
          dirty_q[addr_i][sel_way] <= 1'b1;
        end else begin
          tag_q[addr_i][sel_way]   <= tag_i;
          valid_q[addr_i][sel_way] <= 1'b1;
          dirty_q[addr_i][sel_way] <= 1'b0;
        end
      end

      if ((state_q == ST_IDLE) && flush_i) begin
        inv_q     <= flush_inv_i;
        set_ptr_q <= '0;
        way_ptr_q <= '0;
      end

      if (scan_skip && inv_q)
        valid_q[set_ptr_q][way_ptr_q] <= 1'b0;

      if (wb_fire) begin
        dirty_q[set_ptr_q][way_ptr_q] <= 1'b0;
        valid_q[set_ptr_q][way_ptr_q] <= !inv_q;
      end

      // Way first, then set; the pointer wrap after the last line is harmless as DONE follows.
      if (advance) begin
        way_ptr_q <= way_ptr_q + WAY_W'(1);
        if (way_ptr_q == WAY_W'(WAYS - 1))
          set_ptr_q <= set_ptr_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Self-checking bench for dcache_sram_nway: directed scenarios plus random accesses against a
// recency-list cache model, with flush, write-back handshake and reset-during-flush checks.
module tb_dcache_sram_nway;
  localparam int WAYS   = 4;
  localparam int SETS   = 16;
  localparam int TAG_W  = 23;
  localparam int LINE_W = 256;
  localparam int IDX_W  = 4;

  localparam logic [TAG_W-1:0] T_A = 23'h0000A;
  localparam logic [TAG_W-1:0] T_B = 23'h0000B;
  localparam logic [TAG_W-1:0] T_C = 23'h0000C;
  localparam logic [TAG_W-1:0] T_D = 23'h0000D;
  localparam logic [TAG_W-1:0] T_E = 23'h0000E;
  localparam logic [TAG_W-1:0] T_F = 23'h0000F;
  localparam logic [LINE_W-1:0] DEAD = {8{32'hDEAD_BEEF}};

  logic              clk_i, rst_i, enable_i, write_i;
  logic [IDX_W-1:0]  addr_i;
  logic [TAG_W-1:0]  tag_i;
  logic [LINE_W-1:0] data_i;
  logic [TAG_W+1:0]  tag_o;
  logic [LINE_W-1:0] data_o;
  logic              hit_o, flush_i, flush_inv_i, flush_busy_o, flush_done_o;
  logic              wb_valid_o, wb_ready_i;
  logic [IDX_W-1:0]  wb_idx_o;
  logic [TAG_W-1:0]  wb_tag_o;
  logic [LINE_W-1:0] wb_data_o;

  dcache_sram_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .write_i(write_i), .addr_i(addr_i),
    .tag_i(tag_i), .data_i(data_i), .tag_o(tag_o), .data_o(data_o), .hit_o(hit_o),
    .flush_i(flush_i), .flush_inv_i(flush_inv_i), .flush_busy_o(flush_busy_o),
    .flush_done_o(flush_done_o), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_idx_o(wb_idx_o), .wb_tag_o(wb_tag_o), .wb_data_o(wb_data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Reference model: per-line state plus a recency list per set (front = most recently used).
  logic              m_valid [SETS][WAYS];
  logic              m_dirty [SETS][WAYS];
  logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
  logic [LINE_W-1:0] m_data  [SETS][WAYS];
  int                m_lru   [SETS][$];

  logic              obs_hit;
  logic [TAG_W+1:0]  obs_tag;
  logic [LINE_W-1:0] obs_data;

  task automatic check(input string name, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int s = 0; s < SETS; s++) begin
      m_lru[s].delete();
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = '0;
        m_data[s][w]  = '0;
        m_lru[s].push_back(w);
      end
    end
  endtask

  function automatic int m_find(input int s, input logic [TAG_W-1:0] t);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  function automatic int m_victim(input int s);
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[s][w]) return w;
    return m_lru[s][WAYS-1];
  endfunction

  task automatic m_touch(input int s, input int w);
    for (int i = 0; i < m_lru[s].size(); i++)
      if (m_lru[s][i] == w) begin
        m_lru[s].delete(i);
        break;
      end
    m_lru[s].push_front(w);
  endtask

  function automatic logic [LINE_W-1:0] line_of(input logic [TAG_W-1:0] t);
    return {8{32'hC0DE_0000 ^ 32'(t)}};
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One enabled cycle: check the combinational lookup against the model, clock it, update the model.
  task automatic access(input logic wr, input int s, input logic [TAG_W-1:0] t, input logic [LINE_W-1:0] d);
    int hw, sw;
    enable_i = 1'b1;
    write_i  = wr;
    addr_i   = IDX_W'(s);
    tag_i    = t;
    data_i   = d;
    #1;
    hw = m_find(s, t);
    sw = (hw >= 0) ? hw : m_victim(s);
    check($sformatf("acc_hit s%0d", s), LINE_W'(hit_o), LINE_W'(hw >= 0));
    check($sformatf("acc_tag s%0d", s), LINE_W'(tag_o), LINE_W'({m_valid[s][sw], m_dirty[s][sw], m_tag[s][sw]}));
    check($sformatf("acc_data s%0d", s), data_o, m_data[s][sw]);
    obs_hit  = hit_o;
    obs_tag  = tag_o;
    obs_data = data_o;
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    if (wr) begin
      m_data[s][sw] = d;
      if (hw >= 0) begin
        m_dirty[s][sw] = 1'b1;
      end else begin
        m_tag[s][sw]   = t;
        m_valid[s][sw] = 1'b1;
        m_dirty[s][sw] = 1'b0;
      end
      m_touch(s, sw);
    end else if (hw >= 0) begin
      m_touch(s, hw);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; enable_i = 1'b1; write_i = 1'b0; addr_i = 4'd3; tag_i = '0;
    data_i = '0; flush_i = 1'b0; flush_inv_i = 1'b0; wb_ready_i = 1'b0;
    @(posedge clk_i); #1;
    check("rst_hit", LINE_W'(hit_o), '0);
    check("rst_tag", LINE_W'(tag_o), '0);
    check("rst_data", data_o, '0);
    check("rst_busy", LINE_W'(flush_busy_o), '0);
    check("rst_done", LINE_W'(flush_done_o), '0);
    check("rst_wbv", LINE_W'(wb_valid_o), '0);
    check("rst_wbidx", LINE_W'(wb_idx_o), '0);
    check("rst_wbtag", LINE_W'(wb_tag_o), '0);
    check("rst_wbdata", wb_data_o, '0);
    rst_i    = 1'b0;
    enable_i = 1'b0;
    m_reset();
  endtask

  // Runs one flush to completion; the first write-back is held off for `stall` cycles.
  task automatic flush_run(input bit inv, input int stall, input bit rnd_ready);
    int  exp_s[$], exp_w[$];
    int  n_hs, n_done, waited;
    bit  finished, accept;
    n_hs = 0; n_done = 0; waited = 0; finished = 1'b0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (m_valid[s][w] && m_dirty[s][w]) begin
          exp_s.push_back(s);
          exp_w.push_back(w);
        end
    enable_i = 1'b0; flush_i = 1'b1; flush_inv_i = inv;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    check("flush_busy_start", LINE_W'(flush_busy_o), LINE_W'(1));
    enable_i = 1'b1; write_i = 1'b0; addr_i = '0; tag_i = m_tag[0][0];
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!flush_busy_o) begin
        finished = 1'b1;
        break;
      end
      if (flush_done_o) n_done++;
      check("flush_hit", LINE_W'(hit_o), '0);
      check("flush_tag", LINE_W'(tag_o), '0);
      flush_i     = (cyc == 5);
      flush_inv_i = !inv;
      wb_ready_i  = 1'b0;
      if (wb_valid_o) begin
        if (n_hs < exp_s.size()) begin
          check("wb_idx", LINE_W'(wb_idx_o), LINE_W'(exp_s[n_hs]));
          check("wb_tag", LINE_W'(wb_tag_o), LINE_W'(m_tag[exp_s[n_hs]][exp_w[n_hs]]));
          check("wb_data", wb_data_o, m_data[exp_s[n_hs]][exp_w[n_hs]]);
        end
        accept = !(n_hs == 0 && waited < stall) && (!rnd_ready || $urandom_range(1, 0) == 1);
        if (accept) begin
          wb_ready_i = 1'b1;
          n_hs++;
        end else if (n_hs == 0) begin
          waited++;
        end
      end
      @(posedge clk_i); #1;
    end
    enable_i = 1'b0; flush_i = 1'b0; flush_inv_i = 1'b0; wb_ready_i = 1'b0;
    check("flush_finished", LINE_W'(finished), LINE_W'(1));
    check("flush_handshakes", LINE_W'(n_hs), LINE_W'(exp_s.size()));
    check("flush_done_pulses", LINE_W'(n_done), LINE_W'(1));
    check("flush_done_after", LINE_W'(flush_done_o), '0);
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_dirty[s][w] = 1'b0;
        if (inv) m_valid[s][w] = 1'b0;
      end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    int  s;
    bit  seen;
    logic [TAG_W-1:0] t;
    rst_i = 1'b1; enable_i = 1'b0; write_i = 1'b0; addr_i = '0; tag_i = '0; data_i = '0;
    flush_i = 1'b0; flush_inv_i = 1'b0; wb_ready_i = 1'b0;
    m_reset();
    do_reset();

    // Empty lookup, then fill set 3 and hit on C.
    access(1'b0, 3, 23'h1A, '0);
    check("empty_valid_bit", LINE_W'(obs_tag[TAG_W+1]), '0);
    access(1'b1, 3, T_A, line_of(T_A));
    access(1'b1, 3, T_B, line_of(T_B));
    access(1'b1, 3, T_C, line_of(T_C));
    access(1'b1, 3, T_D, line_of(T_D));
    access(1'b0, 3, T_C, '0);
    check("set3_hit_c", LINE_W'(obs_hit), LINE_W'(1));
    check("set3_data_c", obs_data, line_of(T_C));

    // A disabled request shows nothing even for a resident tag.
    enable_i = 1'b0; addr_i = 4'd3; tag_i = T_C;
    #1;
    check("disabled_hit", LINE_W'(hit_o), '0);
    check("disabled_tag", LINE_W'(tag_o), '0);
    check("disabled_data", data_o, '0);
    @(posedge clk_i); #1;

    // LRU ordering on set 5.
    access(1'b1, 5, T_A, line_of(T_A));
    access(1'b1, 5, T_B, line_of(T_B));
    access(1'b1, 5, T_C, line_of(T_C));
    access(1'b1, 5, T_D, line_of(T_D));
    access(1'b0, 5, T_A, '0);
    access(1'b1, 5, T_E, line_of(T_E));
    check("lru_victim_b", LINE_W'(obs_tag), LINE_W'({1'b1, 1'b0, T_B}));
    access(1'b0, 5, T_B, '0);
    check("lru_b_evicted", LINE_W'(obs_hit), '0);
    access(1'b0, 5, T_C, '0);
    access(1'b0, 5, T_D, '0);
    access(1'b1, 5, T_F, line_of(T_F));
    check("lru_victim_a", LINE_W'(obs_tag), LINE_W'({1'b1, 1'b0, T_A}));
    access(1'b0, 5, T_F, '0);
    check("lru_f_data", obs_data, line_of(T_F));

    // Write hit makes the line dirty; a later write miss exposes it as the victim.
    access(1'b1, 2, T_A, line_of(T_A));
    access(1'b1, 2, T_A, DEAD);
    access(1'b0, 2, T_A, '0);
    check("wr_hit_tag", LINE_W'(obs_tag), LINE_W'({1'b1, 1'b1, T_A}));
    check("wr_hit_data", obs_data, DEAD);
    access(1'b1, 2, T_B, line_of(T_B));
    access(1'b1, 2, T_C, line_of(T_C));
    access(1'b1, 2, T_D, line_of(T_D));
    access(1'b1, 2, T_E, line_of(T_E));
    check("dirty_victim_tag", LINE_W'(obs_tag), LINE_W'({1'b1, 1'b1, T_A}));
    check("dirty_victim_data", obs_data, DEAD);

    // Flush without invalidate: dirty lines only at (0,1) and (15,3).
    do_reset();
    access(1'b1, 0, T_A, line_of(T_A));
    access(1'b1, 0, T_B, line_of(T_B));
    access(1'b1, 0, T_C, line_of(T_C));
    access(1'b1, 0, T_D, line_of(T_D));
    access(1'b1, 0, T_B, rand_line());
    access(1'b1, 15, T_A, line_of(T_A));
    access(1'b1, 15, T_B, line_of(T_B));
    access(1'b1, 15, T_C, line_of(T_C));
    access(1'b1, 15, T_D, line_of(T_D));
    access(1'b1, 15, T_D, rand_line());
    access(1'b1, 7, T_E, line_of(T_E));
    flush_run(1'b0, 3, 1'b0);
    for (int si = 0; si < SETS; si++)
      for (int w = 0; w < WAYS; w++)
        if (m_valid[si][w]) access(1'b0, si, m_tag[si][w], '0);
    access(1'b0, 15, T_D, '0);
    check("post_flush_clean", LINE_W'(obs_tag), LINE_W'({1'b1, 1'b0, T_D}));

    // Random traffic on a few busy sets plus occasional scattered sets.
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(1, 0) == 1) ? int'($urandom_range(3, 0)) : int'($urandom_range(SETS - 1, 0));
      t = TAG_W'(32'h40000 + $urandom_range(5, 0));
      access($urandom_range(1, 0) == 1, s, t, rand_line());
    end

    // Flush with invalidate and a randomly throttled write-back sink.
    flush_run(1'b1, 0, 1'b1);
    for (int si = 0; si < SETS; si++)
      for (int k = 0; k < 6; k++) begin
        access(1'b0, si, TAG_W'(32'h40000 + k), '0);
        check("inv_valid_bit", LINE_W'(obs_tag[TAG_W+1]), '0);
      end

    // Reset while a line is being presented for write-back; the flush-start access still lands.
    access(1'b1, 0, T_A, line_of(T_A));
    flush_i = 1'b1; flush_inv_i = 1'b0;
    access(1'b1, 0, T_A, DEAD);
    flush_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (wb_valid_o) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk_i); #1;
    end
    check("emit_reached", LINE_W'(seen), LINE_W'(1));
    check("emit_idx", LINE_W'(wb_idx_o), '0);
    check("emit_tag", LINE_W'(wb_tag_o), LINE_W'(T_A));
    check("emit_data", wb_data_o, DEAD);
    rst_i = 1'b1;
    #1;
    check("midrst_wbv", LINE_W'(wb_valid_o), '0);
    check("midrst_busy", LINE_W'(flush_busy_o), '0);
    do_reset();
    access(1'b0, 0, T_A, '0);
    check("midrst_miss", LINE_W'(obs_hit), '0);
    check("midrst_invalid", LINE_W'(obs_tag[TAG_W+1]), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
